// File: rtl/mem_arbiter_if.sv
// Pipeline-side and memory-port-side signals of mem_arbiter.
// slave: the arbiter's view. master: the pipeline and memory side driving it.
interface mem_arbiter_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        flush_i;
    logic        stallreq_o;
    logic        err_o;

    modport slave (
        input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_sel_i, mem_addr_i,
               mem_wdata_i, bus_rdata_i, bus_ack_i, flush_i,
        output if_rdata_o, if_ack_o, mem_rdata_o, mem_ack_o, bus_req_o, bus_we_o,
               bus_sel_o, bus_addr_o, bus_wdata_o, stallreq_o, err_o
    );

    modport master (
        output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_sel_i, mem_addr_i,
               mem_wdata_i, bus_rdata_i, bus_ack_i, flush_i,
        input  if_rdata_o, if_ack_o, mem_rdata_o, mem_ack_o, bus_req_o, bus_we_o,
               bus_sel_o, bus_addr_o, bus_wdata_o, stallreq_o, err_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto one memory port; request-to-ack latency 2 cycles minimum.
// Requesters stall until acked; optional bus timeout enabled by macro ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  p
);
    typedef enum logic [1:0] {IDLE, IF_WAIT, MEM_WAIT} state_t;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT out of range 1..255");
    end

    state_t      state;
    logic        last_mem;
    logic        flushed;
    logic        bus_req;
    logic        lat_we;
    logic [3:0]  lat_sel;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] if_rdata;
    logic [31:0] mem_rdata;
    logic        if_ack;
    logic        mem_ack;
    logic        tmo;

    logic if_elig, mem_elig, grant_mem, grant_if, if_drop;

    // A requester whose ack is showing this cycle is already served.
    assign if_elig   = p.if_req_i & ~if_ack & ~p.flush_i;
    assign mem_elig  = p.mem_req_i & ~mem_ack;
    assign grant_mem = mem_elig & (~if_elig | ~last_mem);
    assign grant_if  = if_elig & ~grant_mem;
    assign if_drop   = flushed | p.flush_i;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] tcnt;
    logic       err;
    assign tmo     = (tcnt == 8'(TIMEOUT - 1));
    assign p.err_o = err;
`else
    assign tmo     = 1'b0;
    assign p.err_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_mem  <= 1'b0;
            flushed   <= 1'b0;
            bus_req   <= 1'b0;
            lat_we    <= 1'b0;
            lat_sel   <= 4'h0;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            if_rdata  <= 32'h0;
            mem_rdata <= 32'h0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tcnt      <= 8'h0;
            err       <= 1'b0;
`endif
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            err     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (grant_mem) begin
                        state     <= MEM_WAIT;
                        bus_req   <= 1'b1;
                        last_mem  <= 1'b1;
                        flushed   <= 1'b0;
                        lat_we    <= p.mem_we_i;
                        lat_sel   <= p.mem_sel_i;
                        lat_addr  <= p.mem_addr_i;
                        lat_wdata <= p.mem_wdata_i;
`ifdef ARB_TIMEOUT_EN
                        tcnt      <= 8'h0;
`endif
                    end else if (grant_if) begin
                        state     <= IF_WAIT;
                        bus_req   <= 1'b1;
                        last_mem  <= 1'b0;
                        flushed   <= 1'b0;
                        lat_we    <= 1'b0;
                        lat_sel   <= 4'hF;
                        lat_addr  <= p.if_addr_i;
                        lat_wdata <= 32'h0;
`ifdef ARB_TIMEOUT_EN
                        tcnt      <= 8'h0;
`endif
                    end
                end
                IF_WAIT: begin
                    // A flushed fetch still finishes on the bus but is never reported.
                    if (p.bus_ack_i || tmo) begin
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        if (!if_drop) begin
                            if_ack   <= 1'b1;
                            if_rdata <= p.bus_ack_i ? p.bus_rdata_i : 32'h0;
                        end
`ifdef ARB_TIMEOUT_EN
                        err <= ~p.bus_ack_i;
`endif
                    end else begin
                        if (p.flush_i) flushed <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        tcnt <= tcnt + 8'h1;
`endif
                    end
                end
                MEM_WAIT: begin
                    if (p.bus_ack_i || tmo) begin
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        mem_ack <= 1'b1;
                        if (!p.bus_ack_i)
                            mem_rdata <= 32'h0;
                        else if (!lat_we)
                            mem_rdata <= p.bus_rdata_i;
`ifdef ARB_TIMEOUT_EN
                        err <= ~p.bus_ack_i;
`endif
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        tcnt <= tcnt + 8'h1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign p.bus_req_o   = bus_req;
    assign p.bus_we_o    = lat_we;
    assign p.bus_sel_o   = lat_sel;
    assign p.bus_addr_o  = lat_addr;
    assign p.bus_wdata_o = lat_wdata;
    assign p.if_rdata_o  = if_rdata;
    assign p.if_ack_o    = if_ack;
    assign p.mem_rdata_o = mem_rdata;
    assign p.mem_ack_o   = mem_ack;
    assign p.stallreq_o  = (p.mem_req_i & ~mem_ack) | (p.if_req_i & ~if_ack);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; inputs change and outputs are sampled 2 ns after each rising edge.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter_if a ();
    mem_arbiter #(.TIMEOUT(4)) dut (.clk(clk), .rst(rst), .p(a));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a.if_req_i = 0; a.if_addr_i = 0; a.mem_req_i = 0; a.mem_we_i = 0;
        a.mem_sel_i = 0; a.mem_addr_i = 0; a.mem_wdata_i = 0;
        a.bus_rdata_i = 0; a.bus_ack_i = 0; a.flush_i = 0;

        // reset state
        tick(); tick();
        chk("rst_bus_req", a.bus_req_o, 0);
        chk("rst_acks", {a.if_ack_o, a.mem_ack_o, a.err_o}, 0);
        chk("rst_rdata", {a.if_rdata_o, a.mem_rdata_o}, 0);
        chk("rst_stall", a.stallreq_o, 0);
        rst = 0;

        // single fetch, ack one cycle after bus_req
        a.if_req_i = 1; a.if_addr_i = 32'h100;
        #1 chk("f_stall_req", a.stallreq_o, 1);
        tick();
        chk("f_bus_req", a.bus_req_o, 1);
        chk("f_bus_addr", a.bus_addr_o, 32'h100);
        chk("f_we_sel", {a.bus_we_o, a.bus_sel_o}, 5'h0F);
        chk("f_no_ack_yet", a.if_ack_o, 0);
        a.bus_ack_i = 1; a.bus_rdata_i = 32'h3C010001;
        tick();
        a.bus_ack_i = 0;
        chk("f_ack", a.if_ack_o, 1);
        chk("f_rdata", a.if_rdata_o, 32'h3C010001);
        chk("f_bus_req_drop", a.bus_req_o, 0);
        chk("f_stall_ack", a.stallreq_o, 0);
        tick();
        chk("f_ack_once", a.if_ack_o, 0);
        chk("f_no_regrant", a.bus_req_o, 0);
        a.if_req_i = 0;
        tick();

        // contention with immediate acks: MEM, IF, MEM, IF
        a.if_addr_i = 32'h400; a.mem_addr_i = 32'h500; a.mem_we_i = 0; a.mem_sel_i = 4'hF;
        a.if_req_i = 1; a.mem_req_i = 1; a.bus_ack_i = 1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rr_mem_grant", {a.bus_req_o, a.bus_addr_o}, {1'b1, 32'h500});
            a.bus_rdata_i = 32'hA0 + k;
            tick();
            chk("rr_mem_ack", {a.mem_ack_o, a.if_ack_o}, 2'b10);
            chk("rr_mem_rdata", a.mem_rdata_o, 32'hA0 + k);
            chk("rr_stall_mack", a.stallreq_o, 1);
            tick();
            chk("rr_if_grant", {a.bus_req_o, a.bus_addr_o}, {1'b1, 32'h400});
            a.bus_rdata_i = 32'hB0 + k;
            tick();
            chk("rr_if_ack", {a.mem_ack_o, a.if_ack_o}, 2'b01);
            chk("rr_if_rdata", a.if_rdata_o, 32'hB0 + k);
        end
        a.if_req_i = 0; a.mem_req_i = 0; a.bus_ack_i = 0;
        tick();

        // write with ack delayed 5 cycles; request inputs change under it
        a.mem_req_i = 1; a.mem_we_i = 1; a.mem_sel_i = 4'b0011;
        a.mem_addr_i = 32'h200; a.mem_wdata_i = 32'hDEADBEEF;
        tick();
        a.mem_addr_i = 32'hFFF; a.mem_wdata_i = 32'h0; a.mem_sel_i = 4'hF;
        for (int k = 0; k < 6; k++) begin
            chk("w_addr", a.bus_addr_o, 32'h200);
            chk("w_wdata", a.bus_wdata_o, 32'hDEADBEEF);
            chk("w_ctl", {a.bus_req_o, a.bus_we_o, a.bus_sel_o, a.mem_ack_o}, 7'b1100110);
            if (k == 5) begin
                a.bus_ack_i = 1; a.bus_rdata_i = 32'h12345678;
            end
            tick();
        end
        a.bus_ack_i = 0; a.mem_req_i = 0; a.mem_we_i = 0;
        chk("w_ack", a.mem_ack_o, 1);
        chk("w_rdata_kept", a.mem_rdata_o, 32'hA1);
        tick();
        chk("w_ack_once", a.mem_ack_o, 0);

        // flush during IF_WAIT, pending MEM granted afterwards
        a.if_req_i = 1; a.if_addr_i = 32'h600;
        tick();
        chk("fl_if_grant", {a.bus_req_o, a.bus_addr_o}, {1'b1, 32'h600});
        a.flush_i = 1;
        tick();
        a.flush_i = 0; a.mem_req_i = 1; a.mem_addr_i = 32'h700; a.mem_sel_i = 4'hF;
        tick();
        chk("fl_still_wait", a.bus_req_o, 1);
        a.bus_ack_i = 1; a.bus_rdata_i = 32'h999; a.if_req_i = 0;
        tick();
        a.bus_ack_i = 0;
        chk("fl_no_ack", a.if_ack_o, 0);
        chk("fl_rdata_kept", a.if_rdata_o, 32'hB1);
        chk("fl_idle", a.bus_req_o, 0);
        tick();
        chk("fl_mem_next", {a.bus_req_o, a.bus_addr_o, a.bus_we_o}, {1'b1, 32'h700, 1'b0});
        a.bus_ack_i = 1; a.bus_rdata_i = 32'h77;
        tick();
        a.bus_ack_i = 0; a.mem_req_i = 0;
        chk("fl_mem_ack", {a.mem_ack_o, a.mem_rdata_o}, {1'b1, 32'h77});
        tick();

        // flush in IDLE blocks the fetch grant for that cycle only
        a.if_req_i = 1; a.if_addr_i = 32'h800; a.flush_i = 1;
        tick();
        chk("fi_blocked", a.bus_req_o, 0);
        a.flush_i = 0;
        tick();
        chk("fi_granted", {a.bus_req_o, a.bus_addr_o}, {1'b1, 32'h800});
        a.bus_ack_i = 1; a.bus_rdata_i = 32'h88;
        tick();
        a.bus_ack_i = 0; a.if_req_i = 0;
        chk("fi_ack", {a.if_ack_o, a.if_rdata_o}, {1'b1, 32'h88});
        tick();

        // bus never acks
        a.mem_req_i = 1; a.mem_addr_i = 32'h900; a.mem_we_i = 0;
        tick();
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            chk("to_req_high", {a.bus_req_o, a.err_o, a.mem_ack_o}, 3'b100);
            tick();
        end
        chk("to_expire", {a.bus_req_o, a.err_o, a.mem_ack_o}, 3'b011);
        chk("to_rdata", a.mem_rdata_o, 32'h0);
        a.mem_req_i = 0;
        tick();
        chk("to_err_once", {a.err_o, a.mem_ack_o}, 2'b00);
        a.mem_req_i = 1;
        tick();
`else
        for (int k = 0; k < 10; k++) tick();
        chk("to_hang", {a.bus_req_o, a.err_o, a.mem_ack_o}, 3'b100);
`endif

        // asynchronous reset in MEM_WAIT
        chk("ar_in_wait", a.bus_req_o, 1);
        rst = 1;
        #1;
        chk("ar_bus_req", a.bus_req_o, 0);
        chk("ar_outs", {a.if_ack_o, a.mem_ack_o, a.err_o, a.bus_addr_o}, 0);
        chk("ar_rdata", {a.if_rdata_o, a.mem_rdata_o}, 0);
        tick(); tick();
        rst = 0;
        a.if_req_i = 1; a.if_addr_i = 32'hA00;
        tick();
        chk("ar_first_mem", {a.bus_req_o, a.bus_addr_o}, {1'b1, 32'h900});
        chk("ar_no_ack", {a.if_ack_o, a.mem_ack_o}, 0);
        a.if_req_i = 0; a.mem_req_i = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
